// File: rtl/bus_request_port.sv
// -----------------------------------------------------------------------------
// bus_request_port
//
// Per-unit requester sitting between a local data source and one slot of a
// shared-bus arbiter. Outbound words are buffered in a small FIFO; the port
// raises `request` while words are pending, ages its priority while it waits,
// and places one word on the bus for every cycle its grant bit is high.
//
// Parameters:
//   DATAWIDTH    - width of buffered and bus data
//   ADDRESSWIDTH - width of the priority field (arbiter per-unit slice)
//   FIFODEPTH    - FIFO entries, power of two, >= 2
//   BASEPRIO     - priority after reset and after each grant (lower wins)
//   AGELIMIT     - ungranted requesting cycles per one-step priority boost
//
// Ports:
//   clock            in   sole clock, rising edge
//   reset            in   synchronous, active-high
//   wr_valid         in   local push strobe
//   wr_data          in   word to push
//   wr_ready         out  FIFO not full (combinational from count)
//   request          out  registered request to the arbiter
//   request_priority out  registered priority to the arbiter
//   grant            in   this unit's bit of the registered grant vector
//   bus_valid        out  registered, word on bus_data this cycle
//   bus_data         out  registered bus word
//   fifo_count       out  current FIFO occupancy
//   spurious_grant   out  sticky flag: grant seen while FIFO empty
// -----------------------------------------------------------------------------
module bus_request_port #(
    parameter int DATAWIDTH    = 32,
    parameter int ADDRESSWIDTH = 3,
    parameter int FIFODEPTH    = 8,
    parameter int BASEPRIO     = 3,
    parameter int AGELIMIT     = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_valid,
    input  logic [DATAWIDTH-1:0]         wr_data,
    output logic                         wr_ready,
    output logic                         request,
    output logic [ADDRESSWIDTH-1:0]      request_priority,
    input  logic                         grant,
    output logic                         bus_valid,
    output logic [DATAWIDTH-1:0]         bus_data,
    output logic [$clog2(FIFODEPTH):0]   fifo_count,
    output logic                         spurious_grant
);

    localparam int PW   = $clog2(FIFODEPTH);
    localparam int CW   = PW + 1;
    localparam int AGEW = $clog2(AGELIMIT + 1);

    localparam logic [ADDRESSWIDTH-1:0] BASE_PRIO_VAL = ADDRESSWIDTH'(BASEPRIO);
    localparam logic [AGEW-1:0]         AGE_LAST      = AGEW'(AGELIMIT - 1);
    localparam logic [CW-1:0]           COUNT_FULL    = CW'(FIFODEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [DATAWIDTH-1:0] mem [FIFODEPTH];
    logic [PW-1:0]        head_reg;
    logic [PW-1:0]        tail_reg;
    logic [CW-1:0]        count_reg;
    logic [CW-1:0]        count_next;

    logic                 push;
    logic                 pop;
    logic                 fifo_empty;

    state_t               state_reg;
    state_t               state_next;

    logic [AGEW-1:0]          age_reg;
    logic [ADDRESSWIDTH-1:0]  prio_reg;

    logic                 bus_valid_reg;
    logic [DATAWIDTH-1:0] bus_data_reg;
    logic                 spurious_reg;

    assign fifo_empty = (count_reg == '0);
    assign wr_ready   = (count_reg != COUNT_FULL);
    assign push       = wr_valid & wr_ready;
    assign pop        = grant & ~fifo_empty;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Storage has no reset: after reset the pointers mark everything stale.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[tail_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because FIFODEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PW'(1);
            end
            count_reg <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Bus beat: head word registered out on each grant with data pending.
    // bus_data holds its last value between beats.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            bus_valid_reg <= 1'b0;
            bus_data_reg  <= '0;
        end else begin
            bus_valid_reg <= pop;
            if (pop) begin
                bus_data_reg <= mem[head_reg];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            spurious_reg <= 1'b0;
        end else if (grant && fifo_empty) begin
            spurious_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Request FSM. Decisions use the post-edge occupancy so request drops
    // on the same edge that removes the last word; with the arbiter's
    // one-cycle grant latency the port is then never granted while empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (count_next != '0) state_next = ST_REQ;
            ST_REQ:  if (count_next == '0) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Priority aging: every AGELIMIT ungranted requesting cycles the
    // priority value steps down by one (towards winning), saturating at 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            age_reg  <= '0;
            prio_reg <= BASE_PRIO_VAL;
        end else if (grant || state_reg == ST_IDLE) begin
            age_reg  <= '0;
            prio_reg <= BASE_PRIO_VAL;
        end else if (age_reg == AGE_LAST) begin
            age_reg <= '0;
            if (prio_reg != '0) begin
                prio_reg <= prio_reg - ADDRESSWIDTH'(1);
            end
        end else begin
            age_reg <= age_reg + AGEW'(1);
        end
    end

    assign request          = (state_reg == ST_REQ);
    assign request_priority = prio_reg;
    assign bus_valid        = bus_valid_reg;
    assign bus_data         = bus_data_reg;
    assign fifo_count       = count_reg;
    assign spurious_grant   = spurious_reg;

endmodule

// File: tb/tb_bus_request_port.sv
// -----------------------------------------------------------------------------
// tb_bus_request_port
//
// Directed scenarios followed by randomized traffic. A queue-based model of
// the port is advanced on every rising edge; one compare process checks every
// DUT output against it on each falling edge. Directed scenarios also pin a
// few hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_bus_request_port;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int BASE  = 3;
    localparam int AGE   = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          request;
    logic [AW-1:0] request_priority;
    logic          grant = 1'b0;
    logic          bus_valid;
    logic [DW-1:0] bus_data;
    logic [3:0]    fifo_count;
    logic          spurious_grant;

    bus_request_port #(
        .DATAWIDTH   (DW),
        .ADDRESSWIDTH(AW),
        .FIFODEPTH   (DEPTH),
        .BASEPRIO    (BASE),
        .AGELIMIT    (AGE)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .wr_valid        (wr_valid),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .request         (request),
        .request_priority(request_priority),
        .grant           (grant),
        .bus_valid       (bus_valid),
        .bus_data        (bus_data),
        .fifo_count      (fifo_count),
        .spurious_grant  (spurious_grant)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Behavioural model state (values visible after the most recent edge)
    logic [DW-1:0] m_q[$];
    bit            m_req  = 1'b0;
    int            m_prio = BASE;
    int            m_age  = 0;
    bit            m_bv   = 1'b0;
    logic [DW-1:0] m_bd   = '0;
    bit            m_spur = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the pre-edge inputs.
    task automatic model_step();
        bit do_push;
        bit do_pop;
        bit was_empty;
        if (reset) begin
            m_q.delete();
            m_req  = 1'b0;
            m_prio = BASE;
            m_age  = 0;
            m_bv   = 1'b0;
            m_bd   = '0;
            m_spur = 1'b0;
            return;
        end
        was_empty = (m_q.size() == 0);
        do_push   = wr_valid && (m_q.size() < DEPTH);
        do_pop    = grant && !was_empty;

        if (grant || !m_req) begin
            m_age  = 0;
            m_prio = BASE;
        end else begin
            m_age++;
            if (m_age == AGE) begin
                m_age = 0;
                if (m_prio > 0) m_prio--;
            end
        end

        if (grant && was_empty) m_spur = 1'b1;

        if (do_pop) begin
            m_bd = m_q.pop_front();
            m_bv = 1'b1;
        end else begin
            m_bv = 1'b0;
        end
        if (do_push) m_q.push_back(wr_data);
        m_req = (m_q.size() != 0);
    endtask

    // One clock cycle with the given inputs; returns at the following
    // falling edge, when outputs are stable.
    task automatic cyc(input bit wv, input logic [DW-1:0] wd, input bit g, input bit rst);
        wr_valid = wv;
        wr_data  = wd;
        grant    = g;
        reset    = rst;
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    // Single compare process against the model
    always @(negedge clock) begin
        if (check_en) begin
            chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
            chk("wr_ready", 64'(wr_ready), 64'(m_q.size() < DEPTH));
            chk("request", 64'(request), 64'(m_req));
            chk("priority", 64'(request_priority), 64'(m_prio));
            chk("bus_valid", 64'(bus_valid), 64'(m_bv));
            chk("spurious_grant", 64'(spurious_grant), 64'(m_spur));
            if (m_bv) chk("bus_data", 64'(bus_data), 64'(m_bd));
        end
    end

    initial begin
        int gp;
        // Reset
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check_en = 1'b1;
        cyc(0, 0, 0, 0);
        chk("lit_reset_count", 64'(fifo_count), 64'd0);
        chk("lit_reset_ready", 64'(wr_ready), 64'd1);
        chk("lit_reset_prio", 64'(request_priority), 64'd3);
        chk("lit_reset_bus_data", 64'(bus_data), 64'd0);

        // Reset mid-stream discards buffered words
        for (int i = 0; i < 3; i++) cyc(1, 32'h100 + i, 0, 0);
        chk("lit_three_count", 64'(fifo_count), 64'd3);
        cyc(0, 0, 0, 1);
        chk("lit_rst_count", 64'(fifo_count), 64'd0);
        chk("lit_rst_request", 64'(request), 64'd0);
        chk("lit_rst_prio", 64'(request_priority), 64'd3);
        chk("lit_rst_bus_valid", 64'(bus_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0);
            chk("lit_rst_no_beat", 64'(bus_valid), 64'd0);
        end

        // Single word: push in cycle 0, grant in cycle 2 only
        cyc(1, 32'hA5A5A5A5, 0, 0);
        chk("lit_sw_req_c1", 64'(request), 64'd1);
        cyc(0, 0, 0, 0);
        chk("lit_sw_req_c2", 64'(request), 64'd1);
        cyc(0, 0, 1, 0);
        chk("lit_sw_req_c3", 64'(request), 64'd0);
        chk("lit_sw_valid_c3", 64'(bus_valid), 64'd1);
        chk("lit_sw_data_c3", 64'(bus_data), 64'hA5A5A5A5);
        cyc(0, 0, 0, 0);
        chk("lit_sw_valid_c4", 64'(bus_valid), 64'd0);

        // Fill and overflow
        for (int i = 1; i <= 9; i++) begin
            cyc(1, DW'(i), 0, 0);
            if (i == 8) chk("lit_full_ready", 64'(wr_ready), 64'd0);
        end
        chk("lit_overflow_count", 64'(fifo_count), 64'd8);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 1, 0);
            chk("lit_drain_valid", 64'(bus_valid), 64'd1);
            chk("lit_drain_data", 64'(bus_data), 64'(i));
            chk("lit_drain_request", 64'(request), 64'(i != 8));
        end
        cyc(0, 0, 0, 0);

        // Aging: one word held, no grant
        cyc(1, 32'h77, 0, 0);
        for (int i = 1; i <= 48; i++) begin
            cyc(0, 0, 0, 0);
            if (i == 15) chk("lit_age_15", 64'(request_priority), 64'd3);
            if (i == 16) chk("lit_age_16", 64'(request_priority), 64'd2);
            if (i == 32) chk("lit_age_32", 64'(request_priority), 64'd1);
            if (i == 48) chk("lit_age_48", 64'(request_priority), 64'd0);
        end
        cyc(0, 0, 1, 0);
        chk("lit_age_reload", 64'(request_priority), 64'd3);
        chk("lit_age_beat", 64'(bus_data), 64'h77);

        // Full with simultaneous grant and push
        for (int i = 0; i < 8; i++) cyc(1, 32'h200 + i, 0, 0);
        cyc(1, 32'hDEAD, 1, 0);
        chk("lit_fsg_count", 64'(fifo_count), 64'd7);
        chk("lit_fsg_valid", 64'(bus_valid), 64'd1);
        chk("lit_fsg_data", 64'(bus_data), 64'h200);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);
        chk("lit_fsg_empty", 64'(fifo_count), 64'd0);

        // Spurious grant on empty FIFO
        chk("lit_spur_before", 64'(spurious_grant), 64'd0);
        cyc(0, 0, 1, 0);
        chk("lit_spur_set", 64'(spurious_grant), 64'd1);
        chk("lit_spur_no_beat", 64'(bus_valid), 64'd0);
        cyc(0, 0, 0, 0);
        chk("lit_spur_sticky", 64'(spurious_grant), 64'd1);
        cyc(0, 0, 0, 1);
        chk("lit_spur_cleared", 64'(spurious_grant), 64'd0);

        // Randomized traffic with varying grant density
        for (int i = 0; i < 3000; i++) begin
            case ((i / 200) % 3)
                0: gp = 20;
                1: gp = 60;
                default: gp = 95;
            endcase
            cyc($urandom_range(0, 99) < 70,
                $urandom,
                $urandom_range(0, 99) < gp,
                $urandom_range(0, 299) == 0);
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
